// File: rtl/ps2_pkg.sv
// Shared constants, state types and helpers for the PS/2 arrow-key receiver.
package ps2_pkg;

  // Scan codes of interest
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Start + 8 data + parity + stop
  localparam int unsigned FRAME_LEN = 11;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_SHIFT = 2'd1,
    FR_CHECK = 2'd2
  } frame_state_t;

  typedef enum logic [1:0] {
    DEC_BASE    = 2'd0,
    DEC_EXT     = 2'd1,
    DEC_BRK     = 2'd2,
    DEC_EXT_BRK = 2'd3
  } dec_state_t;

  // True when data plus its parity bit carries an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises kclk/kdata, frames 11-bit words on kclk
// falling edges, aborts a stalled frame after a timeout and validates
// parity/stop before presenting a byte for one cycle.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYC - 1);
  // Index of the last captured bit (stop bit) after the start bit
  localparam logic [3:0]  LAST_IDX     = 4'(FRAME_LEN - 2);

  logic         kclk_meta_r;
  logic         kclk_sync_r;
  logic         kclk_prev_r;
  logic         kdata_meta_r;
  logic         kdata_sync_r;
  logic         fall_s;
  frame_state_t state_r;
  frame_state_t state_nxt_s;
  logic [3:0]   bit_cnt_r;
  logic [9:0]   shift_r;
  logic [16:0]  timer_r;
  logic         timeout_s;
  logic         frame_ok_s;

  // Two-flop synchronisers plus the delayed kclk used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_meta_r  <= 1'b1;
      kclk_sync_r  <= 1'b1;
      kclk_prev_r  <= 1'b1;
      kdata_meta_r <= 1'b1;
      kdata_sync_r <= 1'b1;
    end else begin
      kclk_meta_r  <= kclk;
      kclk_sync_r  <= kclk_meta_r;
      kclk_prev_r  <= kclk_sync_r;
      kdata_meta_r <= kdata;
      kdata_sync_r <= kdata_meta_r;
    end
  end

  assign fall_s = kclk_prev_r & ~kclk_sync_r;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FR_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start bit detection, bit framing and stall timeout
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      FR_IDLE: begin
        if (fall_s && !kdata_sync_r) begin
          state_nxt_s = FR_SHIFT;
        end else begin
          state_nxt_s = FR_IDLE;
        end
      end
      FR_SHIFT: begin
        if (fall_s) begin
          if (bit_cnt_r == LAST_IDX) begin
            state_nxt_s = FR_CHECK;
          end else begin
            state_nxt_s = FR_SHIFT;
          end
        end else if (timer_r == TIMEOUT_LAST) begin
          state_nxt_s = FR_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = FR_SHIFT;
        end
      end
      FR_CHECK: begin
        state_nxt_s = FR_IDLE;
      end
      default: begin
        state_nxt_s = FR_IDLE;
      end
    endcase
  end

  // Bit capture (LSB first into the top of the register), bit count and stall timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r   <= 10'd0;
      bit_cnt_r <= 4'd0;
      timer_r   <= 17'd0;
    end else begin
      if ((state_r == FR_SHIFT) && (state_nxt_s == FR_SHIFT || state_nxt_s == FR_CHECK)) begin
        if (fall_s) begin
          shift_r   <= {kdata_sync_r, shift_r[9:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
          timer_r   <= 17'd0;
        end else begin
          shift_r   <= shift_r;
          bit_cnt_r <= bit_cnt_r;
          timer_r   <= timer_r + 17'd1;
        end
      end else begin
        shift_r   <= shift_r;
        bit_cnt_r <= 4'd0;
        timer_r   <= 17'd0;
      end
    end
  end

  // Frame validation during the single CHECK cycle, plus timeout reporting
  always_comb begin
    frame_ok_s = odd_parity_ok(shift_r[7:0], shift_r[8]) & shift_r[9];
    rx_byte    = shift_r[7:0];
    if (state_r == FR_CHECK) begin
      byte_vld  = frame_ok_s;
      frame_err = ~frame_ok_s;
    end else begin
      byte_vld  = 1'b0;
      frame_err = timeout_s;
    end
  end

endmodule

// File: rtl/ps2_arrow_ctrl.sv
// Arrow-key controller: receives PS/2 bytes and decodes E0/F0-prefixed
// left/right arrow make and break codes into press pulses and held levels.
module ps2_arrow_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter bit          REPEAT_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kclk,
  input  logic kdata,
  output logic left,
  output logic right,
  output logic left_held,
  output logic right_held,
  output logic frame_err
);

  logic [7:0] rx_byte_s;
  logic       byte_vld_s;
  logic       rx_err_s;
  dec_state_t dec_state_r;
  dec_state_t dec_nxt_s;
  logic       left_nxt_s;
  logic       right_nxt_s;
  logic       left_held_nxt_s;
  logic       right_held_nxt_s;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .kclk      (kclk),
    .kdata     (kdata),
    .rx_byte   (rx_byte_s),
    .byte_vld  (byte_vld_s),
    .frame_err (rx_err_s)
  );

  // Decode state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state_r <= DEC_BASE;
      left        <= 1'b0;
      right       <= 1'b0;
      left_held   <= 1'b0;
      right_held  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      dec_state_r <= dec_nxt_s;
      left        <= left_nxt_s;
      right       <= right_nxt_s;
      left_held   <= left_held_nxt_s;
      right_held  <= right_held_nxt_s;
      frame_err   <= rx_err_s;
    end
  end

  // Prefix decoder: advances one step per valid byte, resets on a frame error
  always_comb begin
    dec_nxt_s        = dec_state_r;
    left_nxt_s       = 1'b0;
    right_nxt_s      = 1'b0;
    left_held_nxt_s  = left_held;
    right_held_nxt_s = right_held;
    if (rx_err_s) begin
      dec_nxt_s = DEC_BASE;
    end else if (byte_vld_s) begin
      case (dec_state_r)
        DEC_BASE: begin
          if (rx_byte_s == SC_EXT) begin
            dec_nxt_s = DEC_EXT;
          end else if (rx_byte_s == SC_BRK) begin
            dec_nxt_s = DEC_BRK;
          end else begin
            dec_nxt_s = DEC_BASE;
          end
        end
        DEC_EXT: begin
          if (rx_byte_s == SC_BRK) begin
            dec_nxt_s = DEC_EXT_BRK;
          end else if (rx_byte_s == SC_LEFT) begin
            dec_nxt_s       = DEC_BASE;
            left_held_nxt_s = 1'b1;
            left_nxt_s      = REPEAT_EN | ~left_held;
          end else if (rx_byte_s == SC_RIGHT) begin
            dec_nxt_s        = DEC_BASE;
            right_held_nxt_s = 1'b1;
            right_nxt_s      = REPEAT_EN | ~right_held;
          end else begin
            dec_nxt_s = DEC_BASE;
          end
        end
        DEC_EXT_BRK: begin
          dec_nxt_s = DEC_BASE;
          if (rx_byte_s == SC_LEFT) begin
            left_held_nxt_s = 1'b0;
          end else if (rx_byte_s == SC_RIGHT) begin
            right_held_nxt_s = 1'b0;
          end else begin
            left_held_nxt_s = left_held;
          end
        end
        DEC_BRK: begin
          dec_nxt_s = DEC_BASE;
        end
        default: begin
          dec_nxt_s = DEC_BASE;
        end
      endcase
    end else begin
      dec_nxt_s = dec_state_r;
    end
  end

endmodule
